// File: rtl/riscv_pkg.sv
// Shared definitions for the operand-forwarding controller: select codes and tracker entry.
package riscv_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned SEL_W = 3;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_RF  = 3'd0;
   localparam sel_t SEL_EX  = 3'd1;
   localparam sel_t SEL_MEM = 3'd2;
   localparam sel_t SEL_WB  = 3'd3;
   localparam sel_t SEL_ALT = 3'd4;

   typedef struct packed {
      logic             v;
      logic [REG_W-1:0] rd;
      logic             we;
      logic             ld;
   } trk_entry_t;

   // x0 is never a producer, so a write to it can never be forwarded.
   function automatic logic trk_hit(trk_entry_t e, logic [REG_W-1:0] rs);
      return e.v & e.we & (e.rd != '0) & (e.rd == rs);
   endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode-side bundle of the forwarding controller: instruction fields in, selects/stall out.
interface fwd_hazard_ctrl_if;
   import riscv_pkg::*;

   logic             id_valid;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic [REG_W-1:0] id_rd;
   logic             id_reg_we;
   logic             id_is_load;
   logic             id_a_pc;
   logic             id_b_imm;
   logic             mem_stall;
   logic             flush;
   sel_t             a_sel;
   sel_t             b_sel;
   logic             stall;
   logic             ex_bubble;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_reg_we, id_is_load,
      output id_a_pc, id_b_imm, mem_stall, flush,
      input  a_sel, b_sel, stall, ex_bubble
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_reg_we, id_is_load,
      input  id_a_pc, id_b_imm, mem_stall, flush,
      output a_sel, b_sel, stall, ex_bubble
   );

endinterface

// File: rtl/fwd_sel_calc.sv
// One operand's forwarding select: youngest matching producer wins, alt source overrides all.
module fwd_sel_calc
   import riscv_pkg::*;
(
   input  logic [REG_W-1:0] rs,
   input  logic             alt,
   input  trk_entry_t       ex,
   input  trk_entry_t       mem,
   input  trk_entry_t       wb,
   output sel_t             sel,
   output logic             ex_load_hit
);

   logic hit_ex, hit_mem, hit_wb;

   always_comb begin
      hit_ex  = trk_hit(ex, rs);
      hit_mem = trk_hit(mem, rs);
      hit_wb  = trk_hit(wb, rs);

      sel = SEL_RF;
      if (alt) begin
         sel = SEL_ALT;
      end else if (hit_ex) begin
         sel = SEL_EX;
      end else if (hit_mem) begin
         sel = SEL_MEM;
      end else if (hit_wb) begin
         sel = SEL_WB;
      end

      // An operand replaced by PC/immediate never waits on the load.
      ex_load_hit = !alt & hit_ex & ex.ld;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand-select controller: tracks EX/MEM/WB destinations, drives ALU mux selects, load-use stall.
module fwd_hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned REG_W      = riscv_pkg::REG_W
) (
   input logic              clk,
   input logic              rst_n,
   fwd_hazard_ctrl_if.slave bus
);

   if (NUM_STAGES != 3) begin : g_bad_stages
      $error("fwd_hazard_ctrl supports exactly three tracked stages");
   end
   if (REG_W != riscv_pkg::REG_W) begin : g_bad_regw
      $error("fwd_hazard_ctrl REG_W must match riscv_pkg::REG_W");
   end

   trk_entry_t ex_q, mem_q, wb_q;
   trk_entry_t ex_d;
   logic       a_ld_hit, b_ld_hit;
   logic       load_use;
   sel_t       a_sel_raw, b_sel_raw;

   fwd_sel_calc u_sel_a (
      .rs          (bus.id_rs1),
      .alt         (bus.id_a_pc),
      .ex          (ex_q),
      .mem         (mem_q),
      .wb          (wb_q),
      .sel         (a_sel_raw),
      .ex_load_hit (a_ld_hit)
   );

   fwd_sel_calc u_sel_b (
      .rs          (bus.id_rs2),
      .alt         (bus.id_b_imm),
      .ex          (ex_q),
      .mem         (mem_q),
      .wb          (wb_q),
      .sel         (b_sel_raw),
      .ex_load_hit (b_ld_hit)
   );

   // Flush kills the decode slot, so a pending load-use no longer matters.
   always_comb begin
      load_use = bus.id_valid & (a_ld_hit | b_ld_hit) & !bus.flush;
   end

   always_comb begin
      ex_d    = '0;
      ex_d.v  = bus.id_valid & !load_use & !bus.flush;
      ex_d.rd = bus.id_rd;
      ex_d.we = bus.id_reg_we;
      ex_d.ld = bus.id_is_load;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (!bus.mem_stall) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
      end
   end

   // Outputs stay quiet while reset is held, independent of decode inputs.
   always_comb begin
      bus.a_sel     = SEL_RF;
      bus.b_sel     = SEL_RF;
      bus.stall     = 1'b0;
      bus.ex_bubble = 1'b0;
      if (rst_n) begin
         bus.a_sel = a_sel_raw;
         bus.b_sel = b_sel_raw;
         if (bus.mem_stall) begin
            bus.stall = 1'b1;
         end else begin
            bus.stall     = load_use;
            bus.ex_bubble = load_use;
         end
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: hand-computed selects/stall checked with immediate asserts.
module tb_fwd_hazard_ctrl;
   import riscv_pkg::*;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   fwd_hazard_ctrl_if bus ();

   fwd_hazard_ctrl #(
      .NUM_STAGES (3),
      .REG_W      (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic ld);
      bus.id_valid   = v;
      bus.id_rs1     = rs1;
      bus.id_rs2     = rs2;
      bus.id_rd      = rd;
      bus.id_reg_we  = we;
      bus.id_is_load = ld;
      bus.id_a_pc    = 1'b0;
      bus.id_b_imm   = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      bus.mem_stall = 1'b0;
      bus.flush     = 1'b0;
      #1;
      chk("rst_a_sel", int'(bus.a_sel), 0);
      chk("rst_b_sel", int'(bus.b_sel), 0);
      chk("rst_stall", int'(bus.stall), 0);
      chk("rst_bubble", int'(bus.ex_bubble), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD x5 then a consumer of x5 on both operands
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
      #1;
      chk("add_a_ex", int'(bus.a_sel), 1);
      chk("add_b_ex", int'(bus.b_sel), 1);
      chk("add_nostall", int'(bus.stall), 0);
      bus.id_b_imm = 1'b1;
      #1;
      chk("b_imm_override", int'(bus.b_sel), 4);
      bus.id_a_pc = 1'b1;
      #1;
      chk("a_pc_override", int'(bus.a_sel), 4);
      bus.id_a_pc  = 1'b0;
      bus.id_b_imm = 1'b0;

      // Asynchronous reset mid-stream: EX=x6, MEM=x5 cleared without a clock edge
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_a_sel", int'(bus.a_sel), 0);
      chk("midrst_b_sel", int'(bus.b_sel), 0);
      chk("midrst_stall", int'(bus.stall), 0);
      #1;
      rst_n = 1'b1;
      #1;
      chk("postrst_a_sel", int'(bus.a_sel), 0);

      // Back-to-back writes of x7, then drain
      set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
      tick();
      tick();
      set_id(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      chk("x7_youngest_ex", int'(bus.a_sel), 1);
      tick();
      #1;
      chk("x7_mem", int'(bus.a_sel), 2);
      tick();
      #1;
      chk("x7_wb", int'(bus.a_sel), 3);
      tick();
      #1;
      chk("x7_gone", int'(bus.a_sel), 0);

      // Load-use on rs2
      set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd3, 5'd10, 1'b1, 1'b0);
      #1;
      chk("lu_stall", int'(bus.stall), 1);
      chk("lu_bubble", int'(bus.ex_bubble), 1);
      chk("lu_b_sel", int'(bus.b_sel), 1);
      bus.id_b_imm = 1'b1;
      #1;
      chk("lu_imm_nostall", int'(bus.stall), 0);
      bus.id_b_imm = 1'b0;
      tick();
      #1;
      chk("lu_after_stall", int'(bus.stall), 0);
      chk("lu_after_bubble", int'(bus.ex_bubble), 0);
      chk("lu_after_b_mem", int'(bus.b_sel), 2);
      tick();
      #1;
      chk("lu_load_wb", int'(bus.b_sel), 3);

      // x0 load in EX never forwards or stalls
      set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0);
      #1;
      chk("x0_a_sel", int'(bus.a_sel), 0);
      chk("x0_b_sel", int'(bus.b_sel), 0);
      chk("x0_nostall", int'(bus.stall), 0);

      // mem_stall holds x9 in EX for three cycles
      set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd9, 5'd0, 5'd11, 1'b1, 1'b0);
      bus.mem_stall = 1'b1;
      #1;
      chk("ms_a_sel", int'(bus.a_sel), 1);
      chk("ms_stall", int'(bus.stall), 1);
      chk("ms_bubble", int'(bus.ex_bubble), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         #1;
         chk("ms_hold_a_sel", int'(bus.a_sel), 1);
         chk("ms_hold_stall", int'(bus.stall), 1);
      end
      bus.mem_stall = 1'b0;
      #1;
      chk("ms_release_stall", int'(bus.stall), 0);
      chk("ms_release_a_sel", int'(bus.a_sel), 1);
      tick();

      // Flush kills decoded x4; MEM/WB keep advancing
      set_id(1'b1, 5'd9, 5'd0, 5'd4, 1'b1, 1'b0);
      bus.flush = 1'b1;
      #1;
      chk("fl_a_mem", int'(bus.a_sel), 2);
      chk("fl_stall", int'(bus.stall), 0);
      tick();
      bus.flush = 1'b0;
      set_id(1'b1, 5'd4, 5'd9, 5'd13, 1'b1, 1'b0);
      #1;
      chk("fl_x4_killed", int'(bus.a_sel), 0);
      chk("fl_x9_wb", int'(bus.b_sel), 3);

      // Flush wins over a load-use hazard
      set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd14, 5'd0, 5'd15, 1'b1, 1'b0);
      bus.flush = 1'b1;
      #1;
      chk("fl_lu_stall", int'(bus.stall), 0);
      chk("fl_lu_bubble", int'(bus.ex_bubble), 0);
      bus.flush = 1'b0;
      #1;
      chk("lu_a_stall", int'(bus.stall), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
